// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus, register-file write port and scoreboard signals
// shared between the execute/memory stages, decode and the writeback arbiter.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 3
);
    localparam int NREGS = 1 << REG_AW;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*REG_AW-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      write_en;
    logic [REG_AW-1:0]         write_reg;
    logic [DATA_W-1:0]         write_val;

    logic                      issue_en;
    logic [REG_AW-1:0]         issue_reg;
    logic [REG_AW-1:0]         src1_reg;
    logic [REG_AW-1:0]         src2_reg;
    logic                      hazard;
    logic [NREGS-1:0]          busy;

    modport master (
        output req_valid, req_reg, req_data, issue_en, issue_reg, src1_reg, src2_reg,
        input  req_ready, write_en, write_reg, write_val, hazard, busy
    );

    modport slave (
        input  req_valid, req_reg, req_data, issue_en, issue_reg, src1_reg, src2_reg,
        output req_ready, write_en, write_reg, write_val, hazard, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus a
// per-register busy scoreboard that gives decode a source-operand hazard flag.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 3
) (
    input logic              clk,
    input logic              rst,
    input logic              clk_en,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREGS = 1 << REG_AW;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               write_en_q, write_en_d;
    logic [REG_AW-1:0]  write_reg_q, write_reg_d;
    logic [DATA_W-1:0]  write_val_q, write_val_d;
    logic [NREGS-1:0]   busy_q, busy_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic               xfer;
    logic [NUM_REQ-1:0] ready_c;

    // Search starts at ptr_q and wraps; sum is one bit wider so the wrap
    // subtraction never overflows.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ))
                sum = sum - (PTR_W+1)'(NUM_REQ);
            cand = sum[PTR_W-1:0];
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        ready_c = '0;
        if (win_found)
            ready_c[win_idx] = clk_en;
    end

    assign xfer = win_found & clk_en;

    always_comb begin
        write_en_d  = xfer;
        write_reg_d = write_reg_q;
        write_val_d = write_val_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            write_reg_d = bus.req_reg[win_idx*REG_AW +: REG_AW];
            write_val_d = bus.req_data[win_idx*DATA_W +: DATA_W];
            ptr_d       = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Issue is applied after the commit clear so a newer writer keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (write_en_q)
            busy_d[write_reg_q] = 1'b0;
        if (bus.issue_en)
            busy_d[bus.issue_reg] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            write_en_q  <= 1'b0;
            write_reg_q <= '0;
            write_val_q <= '0;
            busy_q      <= '0;
        end else if (clk_en) begin
            ptr_q       <= ptr_d;
            write_en_q  <= write_en_d;
            write_reg_q <= write_reg_d;
            write_val_q <= write_val_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.write_en  = write_en_q;
    assign bus.write_reg = write_reg_q;
    assign bus.write_val = write_val_q;
    assign bus.busy      = busy_q;
    assign bus.hazard    = busy_q[bus.src1_reg] | busy_q[bus.src2_reg];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a behavioural model predicts grants,
// busy bits and hazards; a monitor checks every committed write against a queue.
module tb_regfile_wb_arbiter;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 3;

    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } wb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .REG_AW(AW)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .REG_AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (en),
        .bus    (bus)
    );

    // stimulus state
    logic [N-1:0]         rv = '0;
    logic [N-1:0][AW-1:0] rr = '0;
    logic [N-1:0][DW-1:0] rd = '0;
    logic                 iss = 1'b0;
    logic [AW-1:0]        iss_reg = '0, s1 = '0, s2 = '0;

    // reference model state
    int            m_ptr = 0;
    logic [7:0]    m_busy = '0;
    logic          m_wen = 1'b0;
    logic [AW-1:0] m_wreg = '0;
    wb_t           exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mgrant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = '0;
        m_wen  = 1'b0;
        m_wreg = '0;
        exp_q.delete();
    endtask

    task automatic drive();
        bus.req_valid = rv;
        bus.req_reg   = rr;
        bus.req_data  = rd;
        bus.issue_en  = iss;
        bus.issue_reg = iss_reg;
        bus.src1_reg  = s1;
        bus.src2_reg  = s2;
    endtask

    // One clock: drive, check combinational/registered outputs at negedge,
    // then advance the model at the rising edge.
    task automatic cycle();
        int g;
        logic [7:0] nb;
        drive();
        @(negedge clk);
        g = mgrant(rv, m_ptr);
        chk("req_ready", bus.req_ready, (g >= 0 && en) ? (64'd1 << g) : 64'd0);
        chk("busy", bus.busy, m_busy);
        chk("hazard", bus.hazard, m_busy[s1] | m_busy[s2]);
        chk("write_en", bus.write_en, m_wen);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (en) begin
            nb = m_busy;
            if (m_wen) nb[m_wreg] = 1'b0;
            if (iss)   nb[iss_reg] = 1'b1;
            m_busy = nb;
            if (g >= 0) begin
                m_wen  = 1'b1;
                m_wreg = rr[g];
                exp_q.push_back('{r: rr[g], d: rd[g]});
                m_ptr  = (g + 1) % N;
                rv[g]  = 1'b0;
            end else begin
                m_wen = 1'b0;
            end
        end
        #1;
    endtask

    task automatic rst_pulse();
        rv  = '0;
        iss = 1'b0;
        rst = 1'b1;
        model_reset();
        cycle();
        rst = 1'b0;
    endtask

    // Monitor: a freshly loaded write appears after each enabled, non-reset edge.
    logic en_last = 1'b0;
    always @(posedge clk) en_last <= en & ~rst;

    always @(negedge clk) begin
        if (!rst && en_last && bus.write_en) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wb_unexpected: got write r%0d=%0h expected no write", bus.write_reg, bus.write_val);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("write_reg", bus.write_reg, e.r);
                chk("write_val", bus.write_val, e.d);
            end
        end
    end

    initial begin
        drive();
        model_reset();
        cycle();
        rst = 1'b0;
        chk("rst_write_reg", bus.write_reg, 0);
        chk("rst_write_val", bus.write_val, 0);

        // idle
        repeat (5) cycle();

        // single write
        rv[0] = 1'b1; rr[0] = 3'd5; rd[0] = 32'hDEADBEEF;
        repeat (3) cycle();

        // round robin with all requesters valid
        rst_pulse();
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b1; rr[i] = AW'(i + 1); rd[i] = 32'hA000_0000 + i;
        end
        for (int c = 0; c < 6; c++) begin
            cycle();
            for (int i = 0; i < N; i++)
                if (!rv[i]) begin
                    rv[i] = 1'b1; rr[i] = AW'($urandom); rd[i] = 32'hB000_0000 + c * 16 + i;
                end
        end
        cycle();

        // clk_en stall with a pending request and an issue that must not land
        en = 1'b0; iss = 1'b1; iss_reg = 3'd6; s1 = 3'd6;
        repeat (3) cycle();
        en = 1'b1; iss = 1'b0;
        repeat (4) cycle();

        // scoreboard: reserve r3, write it back, then same-edge issue and commit
        rst_pulse();
        iss = 1'b1; iss_reg = 3'd3; cycle();
        iss = 1'b0; s1 = 3'd3; s2 = 3'd0; cycle();
        chk("busy_r3", bus.busy, 8'h08);
        rv[0] = 1'b1; rr[0] = 3'd3; rd[0] = 32'h0000_0333;
        repeat (3) cycle();
        iss = 1'b1; iss_reg = 3'd3; cycle();
        iss = 1'b0; rv[1] = 1'b1; rr[1] = 3'd3; rd[1] = 32'h0000_1333; cycle();
        iss = 1'b1; iss_reg = 3'd3; cycle();
        iss = 1'b0; cycle();
        chk("busy_r3_set_wins", bus.busy[3], 1'b1);

        // async reset while a write is on the port and every register is busy
        rst_pulse();
        for (int k = 0; k < 8; k++) begin
            iss = 1'b1; iss_reg = AW'(k);
            if (k == 7) begin rv[0] = 1'b1; rr[0] = 3'd0; rd[0] = 32'h5555_AAAA; end
            cycle();
        end
        iss = 1'b0;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b1; rr[i] = AW'(i); rd[i] = 32'hC000_0000 + i;
        end
        drive();
        #2;
        chk("pre_rst_write_en", bus.write_en, 1'b1);
        chk("pre_rst_busy", bus.busy, 8'hFF);
        rst = 1'b1;
        #1;
        chk("async_write_en", bus.write_en, 1'b0);
        chk("async_busy", bus.busy, 8'h00);
        model_reset();
        cycle();
        rst = 1'b0;
        drive();
        #1;
        chk("post_rst_grant", bus.req_ready, 3'b001);
        repeat (4) cycle();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!rv[i] && $urandom_range(0, 1) == 1) begin
                    rv[i] = 1'b1; rr[i] = AW'($urandom); rd[i] = $urandom;
                end
            en      = ($urandom_range(0, 9) != 0);
            iss     = ($urandom_range(0, 2) == 0);
            iss_reg = AW'($urandom);
            s1      = AW'($urandom);
            s2      = AW'($urandom);
            cycle();
        end

        // drain
        en = 1'b1; iss = 1'b0;
        repeat (6) cycle();
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 8x32 register file between NUM_REQ writeback requesters (ALU, load unit, debug/loader) using round-robin arbitration with a valid/ready handshake.
- Maintains an 8-entry busy scoreboard: set when an instruction issues with a destination register, cleared when that register's write commits.
- Gives decode a combinational hazard flag for its two source operands.
- Sits between the execute/memory stages and the register file write inputs (write_en, writeReg, write_val), under the same clk/clk_en regime.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8); index 0 has the highest priority after reset.
- DATA_W, 32, write data width; must match the register file.
- REG_AW, 3, register address width (2**REG_AW registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clk_en  in  1  global step enable; when low, no state changes and no handshake completes.
- req_valid  in  NUM_REQ  per-requester write request.
- req_reg  in  NUM_REQ*REG_AW  packed destination registers; requester i uses slice [i*REG_AW +: REG_AW].
- req_data  in  NUM_REQ*DATA_W  packed write data; requester i uses slice [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; combinational.
- write_en  out  1  register-file write enable; registered.
- write_reg  out  REG_AW  register-file write address; registered.
- write_val  out  DATA_W  register-file write data; registered.
- issue_en  in  1  issuing instruction reserves a destination register.
- issue_reg  in  REG_AW  register being reserved.
- src1_reg  in  REG_AW  decode source operand 1.
- src2_reg  in  REG_AW  decode source operand 2.
- hazard  out  1  combinational; high when busy[src1_reg] or busy[src2_reg].
- busy  out  2**REG_AW  scoreboard bits; registered.

Behaviour:
- Reset, asynchronous: write_en=0, write_reg=0, write_val=0, busy=0, round-robin pointer ptr=0.
  - A write accepted but not yet committed is dropped.
  - Reset asserted mid-operation takes effect immediately without waiting for clk.
- Arbitration, combinational:
  - Search req_valid starting at index ptr, wrapping modulo NUM_REQ; the first set index is the winner.
  - req_ready[winner]=clk_en; all other bits are 0.
  - No valid requests: req_ready=0.
- Transfer: requester i completes a transfer on a rising edge where req_valid[i] & req_ready[i].
  - At most one transfer per enabled cycle.
  - A requester must hold valid, reg and data stable until it is granted.
- Output register, on an enabled edge:
  - With a transfer: write_en<=1, write_reg<=req_reg[winner], write_val<=req_data[winner], ptr<=(winner+1) mod NUM_REQ.
  - Without a transfer: write_en<=0, ptr unchanged; write_reg and write_val hold.
- Latency: the register file commits on the next enabled edge after the transfer edge, so a write is visible to register-file reads 2 enabled edges after the handshake. Sustained throughput is 1 write per enabled cycle.
- clk_en low: every register holds, write_en included. The register file is also gated, so no duplicate write occurs.
- Scoreboard, on an enabled edge:
  - Commit clear: busy[write_reg] is cleared when write_en=1.
  - Issue set: busy[issue_reg] is set when issue_en=1.
  - Same register hit by both: set wins, because the issuing instruction is a newer writer.
  - Issue to a register that is already busy leaves it busy. There is no counting; the pipeline guarantees in-order writeback per register.
- Hazard: purely combinational from the registered busy bits. No forwarding of a same-cycle commit.
- Register 0 has no special treatment; it is writable like the others.

Test Plan:
- Reset, then idle: req_valid=0, issue_en=0 for 5 cycles -> write_en=0, busy=0x00, req_ready=0 throughout.
- Single write: req_valid=001, req_reg[0]=5, req_data[0]=0xDEADBEEF -> req_ready=001 in that cycle; next cycle write_en=1, write_reg=5, write_val=0xDEADBEEF; the cycle after, write_en=0.
- Round-robin: all three requesters valid continuously, distinct data -> grants go 0,1,2,0,1,2; write_en stays high every cycle; write_val sequence matches the grant order.
- clk_en stall: assert a request, drop clk_en for 3 cycles -> req_ready=0; write_en, write_reg and busy frozen; the grant completes on the first cycle with clk_en=1.
- Scoreboard: issue_reg=3 -> busy=0x08; src1_reg=3 gives hazard=1. A requester writes r3 -> busy[3] clears on the edge where write_en=1; hazard=0 the next cycle. Same-cycle issue_reg=3 and commit of r3 -> busy[3] stays 1.
- Async reset mid-transfer: assert rst between edges while write_en=1 and busy=0xFF -> write_en, busy and ptr become 0 immediately; the next grant goes to requester 0.
